rail_monitor_sequencer: RTL
===========================

Name: rail_monitor_sequencer

Overview:
- Sequences conversions of the rail-sensing ADC bank (NUMADCS 8-bit channels sharing one start/done handshake).
- Averages each channel over 2^AVG_LOG2 conversions and checks every average against per-channel low/high thresholds.
- Applies debounce with hysteresis and raises per-channel rail fault flags for the power-management logic.
- Sits between the ADC bank controller and the rover supervisory/status registers.

Parameters:
- SYSCLK_FREQ, 100_000_000, system clock frequency in Hz (informational; used for default derivation).
- NUMADCS, 5, number of monitored rails/channels.
- SAMPLE_DIV, 10_000, clock cycles between conversion requests; legal range >= 16.
- AVG_LOG2, 2, log2 of conversions per average; legal range 0..4.
- DEBOUNCE, 3, consecutive disagreeing averages needed to change a fault state; legal range 1..15.
- TIMEOUT_CYC, 256, cycles to wait for adc_done before declaring a timeout.

Ports:
- sclk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  run/stop for the sequencer.
- clr_flags  in  1  one-cycle pulse; clears the sticky flags adc_timeout and overrun.
- adc_start  out  1  one-cycle conversion request to the ADC bank.
- adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
- adc_data  in  [NUMADCS-1:0][7:0]  conversion results.
- low_thresh  in  [NUMADCS-1:0][7:0]  per-channel lower limit, inclusive in-range.
- high_thresh  in  [NUMADCS-1:0][7:0]  per-channel upper limit, inclusive in-range.
- avg_data  out  [NUMADCS-1:0][7:0]  latest per-channel averages.
- avg_valid  out  1  one-cycle pulse when avg_data updates.
- fault  out  [NUMADCS-1:0]  per-channel debounced out-of-range flag.
- any_fault  out  1  OR of fault.
- adc_timeout  out  1  sticky: adc_done not seen within TIMEOUT_CYC.
- overrun  out  1  sticky: period tick arrived while a conversion was outstanding.

Behaviour:
- Reset (async, rstn low): all outputs 0, state IDLE, period counter 0, accumulators 0, sample count 0, debounce counters 0.
- Period counter:
  - Counts 0..SAMPLE_DIV-1 while enable=1; held at 0 while enable=0.
  - A tick occurs when the count is SAMPLE_DIV-1; the counter then wraps to 0.
- States: IDLE, WAIT, AVG, CHECK.
- IDLE:
  - On a tick, adc_start=1 for exactly one cycle; next state WAIT; timeout counter cleared.
- WAIT:
  - On adc_done: adc_data[i] is added into a zero-extended (8+AVG_LOG2)-bit accumulator and the sample count increments.
  - If the count has reached 2^AVG_LOG2, next state AVG; otherwise IDLE.
  - If TIMEOUT_CYC cycles pass without adc_done: adc_timeout<=1; next state IDLE; the sample is dropped; the accumulator is kept.
- AVG (one cycle):
  - avg_data[i] <= acc[i] >> AVG_LOG2 (truncation).
  - avg_valid=1 for this one cycle.
  - Accumulators and sample count cleared; next state CHECK.
- CHECK (one cycle):
  - A channel is out of range when avg < low or avg > high. Equal to a limit counts as in range.
  - If the channel's in/out-of-range status disagrees with fault[i], its debounce counter increments; otherwise the counter resets to 0.
  - When the counter reaches DEBOUNCE, fault[i] toggles and the counter resets to 0.
  - any_fault is registered and updates in the same cycle as fault. Next state IDLE.
- Misconfigured thresholds: if low > high, the channel is always out of range. No special handling.
- Latency:
  - Final adc_done at edge k → avg_valid/avg_data at edge k+1 → fault/any_fault at edge k+2.
- Tick while not in IDLE: no new adc_start and overrun<=1. The tick is otherwise lost.
- adc_done while not in WAIT: ignored.
- clr_flags:
  - Clears adc_timeout and overrun.
  - If a set event happens in the same cycle as clr_flags, set wins.
  - Has no effect on fault.
- enable falling:
  - State goes to IDLE on the next edge and the period counter goes to 0.
  - Accumulators and sample count are cleared, so partial averages are discarded.
  - avg_data, fault and debounce counters are held.
  - An adc_done arriving after that edge is ignored.
- Reset mid-operation: everything returns to reset values immediately, including any adc_start that was asserted.

Test Plan:
- Reset/idle:
  - Stimulus: SAMPLE_DIV=64, enable=1.
  - Response: first adc_start at cycle 64 after rstn release, then every 64 cycles; all outputs 0 before that.
- Averaging:
  - Stimulus: AVG_LOG2=2; channel 0 returns 10, 11, 12, 14.
  - Response: avg_data[0]=11 (47>>2); avg_valid pulses one cycle after the fourth adc_done.
  - Also: all channels at 255 gives avg 255 with no overflow.
- Debounce/hysteresis:
  - Stimulus: DEBOUNCE=3, low=100, high=200; averages 201, 201, 201.
  - Response: fault[0] rises after the third CHECK.
  - Then averages 150, 250, 150, 150, 150: fault[0] clears only after the final 150 (the counter reset on 250).
- Boundary:
  - Stimulus: averages of exactly 100 and 200.
  - Response: in range, no counter increment.
  - Also: low=50, high=40 gives the channel out of range for every average.
- Timeout/overrun:
  - Stimulus: adc_done never returned.
  - Response: adc_timeout=1 at TIMEOUT_CYC cycles after adc_start.
  - Stimulus: SAMPLE_DIV=16 with adc_done delayed 20 cycles.
  - Response: overrun=1.
  - clr_flags pulse clears both flags; a coincident set keeps the flag at 1.
- enable drop:
  - Stimulus: deassert enable after 2 of 4 conversions, then re-enable.
  - Response: the next avg_valid requires 4 fresh conversions; fault and avg_data are unchanged throughout.

Source files
------------

// File: rtl/rail_monitor_sequencer.sv
// rtl/rail_monitor_sequencer.sv - ADC rail sampling, averaging, threshold check and debounced fault flags
module rail_monitor_sequencer #(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int NUMADCS     = 5,
    parameter int SAMPLE_DIV  = SYSCLK_FREQ / 10_000,
    parameter int AVG_LOG2    = 2,
    parameter int DEBOUNCE    = 3,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                    sclk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic                    clr_flags,
    output logic                    adc_start,
    input  logic                    adc_done,
    input  logic [NUMADCS-1:0][7:0] adc_data,
    input  logic [NUMADCS-1:0][7:0] low_thresh,
    input  logic [NUMADCS-1:0][7:0] high_thresh,
    output logic [NUMADCS-1:0][7:0] avg_data,
    output logic                    avg_valid,
    output logic [NUMADCS-1:0]      fault,
    output logic                    any_fault,
    output logic                    adc_timeout,
    output logic                    overrun
);

    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WAIT, AVG, CHECK} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       period_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic [CW-1:0]       sample_cnt;
    logic [AW-1:0]       acc    [NUMADCS];
    logic [3:0]          db_cnt [NUMADCS];
    logic [3:0]          db_nx  [NUMADCS];
    logic [NUMADCS-1:0]  fault_nx;
    logic                tick;
    logic                last_sample;
    logic                tmo_hit;
    logic                start_nx;
    logic                take_sample;
    logic                timeout_set;
    logic                overrun_set;

    assign tick        = enable && (period_cnt == PW'(SAMPLE_DIV - 1));
    assign last_sample = (sample_cnt + 1'b1) == CW'(1 << AVG_LOG2);
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign overrun_set = tick && (state != IDLE);

    always_comb begin
        state_nx    = state;
        start_nx    = 1'b0;
        take_sample = 1'b0;
        timeout_set = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        start_nx = 1'b1;
                        state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (adc_done) begin
                        take_sample = 1'b1;
                        state_nx    = last_sample ? AVG : IDLE;
                    end else if (tmo_hit) begin
                        timeout_set = 1'b1;
                        state_nx    = IDLE;
                    end
                end
                AVG:     state_nx = CHECK;
                CHECK:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Hysteresis: a channel only flips after DEBOUNCE consecutive disagreeing averages.
    always_comb begin
        fault_nx = fault;
        db_nx    = db_cnt;
        if (enable && state == CHECK) begin
            for (int i = 0; i < NUMADCS; i++) begin
                if (((avg_data[i] < low_thresh[i]) || (avg_data[i] > high_thresh[i])) != fault[i]) begin
                    if (db_cnt[i] == 4'(DEBOUNCE - 1)) begin
                        fault_nx[i] = ~fault[i];
                        db_nx[i]    = 4'd0;
                    end else begin
                        db_nx[i] = db_cnt[i] + 4'd1;
                    end
                end else begin
                    db_nx[i] = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            period_cnt  <= '0;
            tmo_cnt     <= '0;
            sample_cnt  <= '0;
            adc_start   <= 1'b0;
            avg_valid   <= 1'b0;
            adc_timeout <= 1'b0;
            overrun     <= 1'b0;
            fault       <= '0;
            any_fault   <= 1'b0;
            avg_data    <= '0;
            for (int i = 0; i < NUMADCS; i++) begin
                acc[i]    <= '0;
                db_cnt[i] <= '0;
            end
        end else begin
            period_cnt <= (!enable || tick) ? '0 : period_cnt + 1'b1;
            tmo_cnt    <= (state == WAIT && state_nx == WAIT) ? tmo_cnt + 1'b1 : '0;
            adc_start  <= start_nx;
            avg_valid  <= enable && (state == AVG);

            if (!enable || state == AVG) begin
                sample_cnt <= '0;
            end else if (take_sample) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            // Set takes priority over a coincident clear.
            if (timeout_set) begin
                adc_timeout <= 1'b1;
            end else if (clr_flags) begin
                adc_timeout <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end

            for (int i = 0; i < NUMADCS; i++) begin
                if (!enable || state == AVG) begin
                    acc[i] <= '0;
                end else if (take_sample) begin
                    acc[i] <= acc[i] + AW'(adc_data[i]);
                end
                if (enable && state == AVG) begin
                    avg_data[i] <= acc[i][AW-1 -: 8];
                end
                db_cnt[i] <= db_nx[i];
            end
            fault     <= fault_nx;
            any_fault <= |fault_nx;
        end
    end

endmodule
